// File: rtl/btn_sw_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// btn_sw_conditioner_pkg : auto-repeat state encoding and counter sizing (rev 1.0)
// ============================================================================
package btn_sw_conditioner_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } rpt_state_t;

   // Bits needed to count 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// ============================================================================
// debounce_chan : sync, debounce, edge pulses and auto-repeat for one input (rev 1.0)
// ============================================================================
module debounce_chan
   import btn_sw_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int HOLD_CYCLES     = 5000000,
   parameter int REPEAT_CYCLES   = 1000000,
   parameter bit REPEAT_EN       = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall,
   output logic rpt
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam int RW = cnt_width(max_int(HOLD_CYCLES, REPEAT_CYCLES));
   localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
   localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;
   logic [RW-1:0] rcnt;
   logic [RW-1:0] rcnt_nxt;
   rpt_state_t    state;
   rpt_state_t    state_nxt;
   logic          rpt_nxt;
   logic          accept;
   logic          go_high;
   logic          go_low;

   // The level flips on the edge where the D-th consecutive disagreeing sample is seen.
   assign accept  = (sync2 != level) && (cnt == DB_LAST);
   assign go_high = accept &  sync2;
   assign go_low  = accept & ~sync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         rise  <= go_high;
         fall  <= go_low;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (accept) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rcnt  <= '0;
         rpt   <= 1'b0;
      end else begin
         state <= state_nxt;
         rcnt  <= rcnt_nxt;
         rpt   <= rpt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rcnt_nxt  = rcnt;
      rpt_nxt   = 1'b0;
      // Release wins over any repeat that would fall on the same edge.
      if (go_low) begin
         state_nxt = IDLE;
         rcnt_nxt  = '0;
      end else begin
         case (state)
            IDLE: begin
               if (go_high) begin
                  rpt_nxt   = 1'b1;
                  rcnt_nxt  = '0;
                  state_nxt = HOLD;
               end
            end
            HOLD: begin
               if (rcnt == HOLD_LAST) begin
                  if (REPEAT_EN) begin
                     rpt_nxt   = 1'b1;
                     rcnt_nxt  = '0;
                     state_nxt = REPEAT;
                  end
               end else begin
                  rcnt_nxt = rcnt + RW'(1);
               end
            end
            REPEAT: begin
               if (rcnt == REP_LAST) begin
                  rpt_nxt  = 1'b1;
                  rcnt_nxt = '0;
               end else begin
                  rcnt_nxt = rcnt + RW'(1);
               end
            end
            default: begin
               state_nxt = IDLE;
               rcnt_nxt  = '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/btn_sw_conditioner.sv
`default_nettype none
// ============================================================================
// btn_sw_conditioner : N_IN independent button/switch conditioning channels (rev 1.0)
// ============================================================================
module btn_sw_conditioner
   import btn_sw_conditioner_pkg::*;
#(
   parameter int              N_IN            = 4,
   parameter int              DEBOUNCE_CYCLES = 50000,
   parameter int              HOLD_CYCLES     = 5000000,
   parameter int              REPEAT_CYCLES   = 1000000,
   parameter logic [N_IN-1:0] REPEAT_EN       = {N_IN{1'b1}}
) (
   input  logic            gclk10,
   input  logic            btn_center,
   input  logic [N_IN-1:0] raw_in,
   output logic [N_IN-1:0] level,
   output logic [N_IN-1:0] rise,
   output logic [N_IN-1:0] fall,
   output logic [N_IN-1:0] rpt
);

   for (genvar i = 0; i < N_IN; i++) begin : g_chan
      debounce_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .HOLD_CYCLES     (HOLD_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES),
         .REPEAT_EN       (REPEAT_EN[i])
      ) u_chan (
         .clk   (gclk10),
         .rst   (btn_center),
         .raw   (raw_in[i]),
         .level (level[i]),
         .rise  (rise[i]),
         .fall  (fall[i]),
         .rpt   (rpt[i])
      );
   end

endmodule
`default_nettype wire
